// File: rtl/stream_pkg.sv
// Shared types and helpers for the narrow/wide stream converters.
package stream_pkg;

  // Widest lane mask the helpers accept; converters zero-extend into this.
  localparam int unsigned MaxLanes = 32;
  localparam int unsigned LaneIdxW = $clog2(MaxLanes);

  typedef logic [LaneIdxW-1:0] lane_idx_t;
  typedef logic [MaxLanes-1:0] lane_mask_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic lane_idx_t lowest_set_idx(input lane_mask_t mask);
    lane_idx_t idx;
    idx = '0;
    for (int i = MaxLanes - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = lane_idx_t'(i);
      end
    end
    return idx;
  endfunction

  // True when exactly one bit of the mask is set.
  function automatic logic onehot0_single(input lane_mask_t mask);
    return (mask != '0) && ((mask & (mask - lane_mask_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/lane_priority_enc.sv
// Lowest-set-lane priority encoder with "any" and "exactly one" flags.
module lane_priority_enc
  import stream_pkg::*;
#(
  parameter int unsigned Lanes = 4,
  localparam int unsigned SelW = $clog2(Lanes)
) (
  input  logic [Lanes-1:0] mask_i,
  output logic [SelW-1:0]  sel_o,
  output logic             any_o,
  output logic             single_o
);

  lane_mask_t w_mask_ext;
  lane_idx_t  w_idx;

  // Widen into the package mask type and decode.
  always_comb begin
    w_mask_ext = lane_mask_t'(mask_i);
    w_idx      = lowest_set_idx(w_mask_ext);
    sel_o      = w_idx[SelW-1:0];
    any_o      = |mask_i;
    single_o   = onehot0_single(w_mask_ext);
  end

  // High index bits are always zero for Lanes below MaxLanes.
  if (SelW < LaneIdxW) begin : g_hi_idx
    logic w_unused_hi;
    assign w_unused_hi = ^w_idx[LaneIdxW-1:SelW];
  end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits kept lanes of each beat in ascending order.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_DATA_RATIO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    drop_o
);

  localparam int unsigned SelW = $clog2(T_DATA_RATIO);

  logic [T_DATA_WIDTH-1:0] r_data_q [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] r_mask_q;
  logic [T_DATA_RATIO-1:0] w_mask_d;
  logic                    r_last_q;
  logic                    w_last_d;
  logic                    r_drop_q;
  logic                    w_drop_d;

  logic [SelW-1:0]         w_sel;
  logic                    w_any;
  logic                    w_single;
  logic [T_DATA_RATIO-1:0] w_sel_oh;
  logic                    w_out_hs;
  logic                    w_in_hs;

  lane_priority_enc #(
    .Lanes (T_DATA_RATIO)
  ) u_enc (
    .mask_i   (r_mask_q),
    .sel_o    (w_sel),
    .any_o    (w_any),
    .single_o (w_single)
  );

  // Handshakes and outputs; s_ready_o looks through m_ready_i so the next beat
  // loads on the same edge the last remaining lane leaves.
  always_comb begin
    m_valid_o = w_any;
    m_data_o  = r_data_q[w_sel];
    m_last_o  = r_last_q & w_single;
    w_out_hs  = w_any & m_ready_i;
    s_ready_o = ~w_any | (w_out_hs & w_single);
    w_in_hs   = s_valid_i & s_ready_o;
    drop_o    = r_drop_q;
  end

  // One-hot of the lane currently presented.
  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      w_sel_oh[i] = (w_sel == SelW'(i));
    end
  end

  // Next-state: retire the presented lane, a new beat overrides.
  always_comb begin
    w_mask_d = r_mask_q;
    w_last_d = r_last_q;
    w_drop_d = 1'b0;
    if (w_out_hs) begin
      w_mask_d = r_mask_q & ~w_sel_oh;
    end
    if (w_in_hs) begin
      w_mask_d = s_keep_i;
      w_last_d = s_last_i;
      w_drop_d = (s_keep_i == '0) & s_last_i;
    end
  end

  // Control state; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask_q <= '0;
      r_last_q <= 1'b0;
      r_drop_q <= 1'b0;
    end else begin
      r_mask_q <= w_mask_d;
      r_last_q <= w_last_d;
      r_drop_q <= w_drop_d;
    end
  end

  // Lane data is only meaningful under the mask, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_data_q <= s_data_i;
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Directed and scoreboarded checks for stream_downsize.
module tb_stream_downsize;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data_i [4];
  logic [3:0] s_keep_i;
  logic       s_last_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       drop_o;

  int unsigned n_vec;
  int unsigned n_err;

  stream_downsize #(
    .T_DATA_WIDTH (8),
    .T_DATA_RATIO (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_keep_i  (s_keep_i),
    .s_last_i  (s_last_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .drop_o    (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] lanes, input logic [3:0] keep, input logic last);
    for (int i = 0; i < 4; i++) s_data_i[i] = lanes[8*i +: 8];
    s_keep_i  = keep;
    s_last_i  = last;
    s_valid_i = 1'b1;
  endtask

  logic [7:0]  exp_w [8];
  logic [8:0]  sb [$];
  logic [8:0]  ent;
  int unsigned idx, sent, cyc, beats_in, hi;
  logic        stalled, pend;
  logic [7:0]  held;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    s_valid_i = 1'b0;
    s_keep_i = '0;
    s_last_i = 1'b0;
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) s_data_i[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(m_valid_o), 0);
    chk("rst_ready", 32'(s_ready_o), 1);
    chk("rst_last", 32'(m_last_o), 0);
    chk("rst_drop", 32'(drop_o), 0);
    rst_n = 1'b1;

    // Full beat, lane 0 first.
    tick();
    set_beat(32'h44332211, 4'b1111, 1'b1);
    m_ready_i = 1'b1;
    @(negedge clk);
    chk("full_rdy0", 32'(s_ready_o), 1);
    tick();
    s_valid_i = 1'b0;
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33; exp_w[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_valid", 32'(m_valid_o), 1);
      chk("full_data", 32'(m_data_o), 32'(exp_w[k]));
      chk("full_last", 32'(m_last_o), 32'(k == 3));
      chk("full_sready", 32'(s_ready_o), 32'(k == 3));
      tick();
    end
    @(negedge clk);
    chk("full_empty", 32'(m_valid_o), 0);

    // Sparse keep 1010: lane 1 then lane 3, back to back.
    tick();
    set_beat(32'hA3A2A1A0, 4'b1010, 1'b1);
    tick();
    s_valid_i = 1'b0;
    exp_w[0] = 8'hA1; exp_w[1] = 8'hA3;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("sparse_valid", 32'(m_valid_o), 1);
      chk("sparse_data", 32'(m_data_o), 32'(exp_w[k]));
      chk("sparse_last", 32'(m_last_o), 32'(k == 1));
      tick();
    end
    @(negedge clk);
    chk("sparse_empty", 32'(m_valid_o), 0);

    // Two full beats with alternating backpressure.
    for (int k = 0; k < 8; k++) exp_w[k] = 8'(k + 1);
    idx = 0; sent = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (idx < 8 && cyc < 40) begin
      tick();
      m_ready_i = (cyc % 2 == 0);
      if (sent == 0) set_beat(32'h04030201, 4'b1111, 1'b0);
      else if (sent == 1) set_beat(32'h08070605, 4'b1111, 1'b1);
      else s_valid_i = 1'b0;
      @(negedge clk);
      if (m_valid_o) begin
        if (stalled) chk("bp_hold", 32'(m_data_o), 32'(held));
        chk("bp_data", 32'(m_data_o), 32'(exp_w[idx]));
        chk("bp_last", 32'(m_last_o), 32'(idx == 7));
        if (m_ready_i) begin
          if (idx == 3) chk("bp_b2b", 32'(s_ready_o), 1);
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = m_data_o;
        end
      end
      if (s_valid_i && s_ready_o) sent++;
      cyc++;
    end
    chk("bp_done", idx, 8);
    tick();
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;

    // Empty-keep beats: silent skip, and a drop pulse when last is set.
    tick();
    set_beat(32'h0, 4'b0000, 1'b0);
    tick();
    s_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("k0_valid", 32'(m_valid_o), 0);
      chk("k0_drop", 32'(drop_o), 0);
      tick();
    end
    set_beat(32'h0, 4'b0000, 1'b1);
    tick();
    s_valid_i = 1'b0;
    @(negedge clk);
    chk("k0l_drop", 32'(drop_o), 1);
    chk("k0l_valid", 32'(m_valid_o), 0);
    tick();
    @(negedge clk);
    chk("k0l_drop_end", 32'(drop_o), 0);

    // Reset in the middle of a buffered beat.
    tick();
    m_ready_i = 1'b0;
    set_beat(32'h55667788, 4'b1111, 1'b1);
    tick();
    s_valid_i = 1'b0;
    @(negedge clk);
    chk("mid_valid", 32'(m_valid_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid_o), 0);
    chk("arst_ready", 32'(s_ready_o), 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("post_rst_valid", 32'(m_valid_o), 0);
    end

    // Random stream against a lane scoreboard.
    beats_in = 0; cyc = 0; pend = 1'b0;
    while (cyc < 20000 && (beats_in < 1000 || sb.size() != 0)) begin
      tick();
      if (!pend) begin
        if (beats_in < 1000 && $urandom_range(3) != 0) begin
          set_beat($urandom, 4'($urandom_range(15)), 1'($urandom_range(1)));
          pend = 1'b1;
        end else begin
          s_valid_i = 1'b0;
        end
      end
      m_ready_i = ($urandom_range(3) != 0);
      @(negedge clk);
      if (m_valid_o) begin
        if (sb.size() == 0) begin
          chk("rnd_underflow", 1, 0);
        end else if (m_ready_i) begin
          ent = sb.pop_front();
          chk("rnd_data", 32'(m_data_o), 32'(ent[7:0]));
          chk("rnd_last", 32'(m_last_o), 32'(ent[8]));
        end
      end
      if (s_valid_i && s_ready_o) begin
        hi = 0;
        for (int i = 0; i < 4; i++) if (s_keep_i[i]) hi = i;
        for (int i = 0; i < 4; i++) begin
          if (s_keep_i[i]) sb.push_back({s_last_i && (i == hi), s_data_i[i]});
        end
        beats_in++;
        pend = 1'b0;
      end
      cyc++;
    end
    chk("rnd_beats", beats_in, 1000);
    chk("rnd_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
